// File: rtl/glitch_det_ctrl.sv
// glitch_det_ctrl: sequencing controller for the delay-line voltage-glitch detector.
// Runs settle, baseline calibration and monitoring with dead-time after each event.
// Keeps a sticky alarm and a saturating event counter.
// Optional macro GLITCH_DIR_EN adds glitch_dir and droop_count outputs.
module glitch_det_ctrl #(
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned CAL_LOG2   = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 16,
    parameter int unsigned EVT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] thresh,
    input  logic             alarm_clr,
    input  logic [CNT_W-1:0] count_in,
    output logic [2:0]       state,
    output logic             busy,
    output logic             armed,
    output logic [CNT_W-1:0] baseline,
    output logic             glitch_pulse,
    output logic             alarm,
`ifdef GLITCH_DIR_EN
    output logic             glitch_dir,
    output logic [EVT_W-1:0] droop_count,
`endif
    output logic [EVT_W-1:0] evt_count
);

    localparam int unsigned ACC_W   = CNT_W + CAL_LOG2;
    localparam int unsigned CAL_N   = 1 << CAL_LOG2;
    localparam int unsigned TMR_M1  = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int unsigned TMR_MAX = (TMR_M1 > CAL_N) ? TMR_M1 : CAL_N;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    // Timer terminal values; a zero-length phase terminates on its first edge.
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] CAL_LAST    = TMR_W'(CAL_N - 1);
    localparam logic [EVT_W-1:0] EVT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAL     = 3'd2,
        S_MONITOR = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   baseline_q, baseline_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [EVT_W-1:0]   evt_q, evt_d;
    logic               alarm_q, alarm_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               armed_q, armed_d;
`ifdef GLITCH_DIR_EN
    logic               dir_q, dir_d;
    logic [EVT_W-1:0]   droop_q, droop_d;
`endif

    logic [ACC_W-1:0]   acc_sum_c;
    logic [CNT_W-1:0]   dev_c;
    logic               below_c;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            acc_q      <= '0;
            baseline_q <= '0;
            thresh_q   <= '0;
            evt_q      <= '0;
            alarm_q    <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
`ifdef GLITCH_DIR_EN
            dir_q      <= 1'b0;
            droop_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            baseline_q <= baseline_d;
            thresh_q   <= thresh_d;
            evt_q      <= evt_d;
            alarm_q    <= alarm_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
`ifdef GLITCH_DIR_EN
            dir_q      <= dir_d;
            droop_q    <= droop_d;
`endif
        end
    end

    // Next-state and datapath update; stop overrides every phase action.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        acc_d      = acc_q;
        baseline_d = baseline_q;
        thresh_d   = thresh_q;
        evt_d      = evt_q;
        alarm_d    = alarm_q;
        pulse_d    = 1'b0;
`ifdef GLITCH_DIR_EN
        dir_d      = dir_q;
        droop_d    = droop_q;
`endif

        acc_sum_c = acc_q + ACC_W'(count_in);
        below_c   = (count_in < baseline_q);
        dev_c     = below_c ? (baseline_q - count_in) : (count_in - baseline_q);

        if (alarm_clr) begin
            alarm_d = 1'b0;
        end

        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        thresh_d = thresh;
                        acc_d    = '0;
                        timer_d  = '0;
                        state_d  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        timer_d = '0;
                        acc_d   = '0;
                        state_d = S_CAL;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_CAL: begin
                    acc_d = acc_sum_c;
                    if (timer_q == CAL_LAST) begin
                        baseline_d = CNT_W'(acc_sum_c >> CAL_LOG2);
                        timer_d    = '0;
                        state_d    = S_MONITOR;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_MONITOR: begin
                    if (dev_c > thresh_q) begin
                        pulse_d = 1'b1;
                        alarm_d = 1'b1;
                        if (evt_q != EVT_MAX) begin
                            evt_d = evt_q + EVT_W'(1);
                        end
`ifdef GLITCH_DIR_EN
                        dir_d = below_c;
                        if (below_c && (droop_q != EVT_MAX)) begin
                            droop_d = droop_q + EVT_W'(1);
                        end
`endif
                        timer_d = '0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        timer_d = '0;
                        state_d = S_MONITOR;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d  = (state_d != S_IDLE);
        armed_d = (state_d == S_MONITOR);
    end

    // Output mapping from registers.
    assign state        = state_q;
    assign busy         = busy_q;
    assign armed        = armed_q;
    assign baseline     = baseline_q;
    assign glitch_pulse = pulse_q;
    assign alarm        = alarm_q;
    assign evt_count    = evt_q;
`ifdef GLITCH_DIR_EN
    assign glitch_dir   = dir_q;
    assign droop_count  = droop_q;
`endif

endmodule

// File: tb/tb_glitch_det_ctrl.sv
// Testbench for glitch_det_ctrl: directed vectors with a pulse scoreboard.
module tb_glitch_det_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stop, alarm_clr;
    logic [6:0]  thresh, count_in;
    logic [2:0]  state;
    logic        busy, armed, glitch_pulse, alarm;
    logic [6:0]  baseline;
    logic [15:0] evt_count;
`ifdef GLITCH_DIR_EN
    logic        glitch_dir;
    logic [15:0] droop_count;
    logic        glitch_dir2;
    logic [2:0]  droop_count2;
`endif

    // Small second instance for zero settle time and counter saturation.
    logic        start2;
    logic [6:0]  count2;
    logic [2:0]  state2;
    logic        busy2, armed2, pulse2, alarm2;
    logic [6:0]  baseline2;
    logic [2:0]  evt2;

    glitch_det_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .thresh(thresh),
        .alarm_clr(alarm_clr), .count_in(count_in), .state(state), .busy(busy),
        .armed(armed), .baseline(baseline), .glitch_pulse(glitch_pulse), .alarm(alarm),
`ifdef GLITCH_DIR_EN
        .glitch_dir(glitch_dir), .droop_count(droop_count),
`endif
        .evt_count(evt_count)
    );

    glitch_det_ctrl #(.CNT_W(7), .CAL_LOG2(1), .SETTLE_CYC(0), .HOLD_CYC(2), .EVT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .thresh(7'd1),
        .alarm_clr(1'b0), .count_in(count2), .state(state2), .busy(busy2),
        .armed(armed2), .baseline(baseline2), .glitch_pulse(pulse2), .alarm(alarm2),
`ifdef GLITCH_DIR_EN
        .glitch_dir(glitch_dir2), .droop_count(droop_count2),
`endif
        .evt_count(evt2)
    );

    typedef struct {
        int cyc;
        int evt;
        int dir;
        int droop;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Detection happens on the next edge; the pulse is visible right after it.
    task automatic expect_pulse(input int evt, input int dir, input int droop);
        exp_t e;
        e.cyc   = cyc + 1;
        e.evt   = evt;
        e.dir   = dir;
        e.droop = droop;
        sbq.push_back(e);
    endtask

    // Monitor: every glitch_pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (glitch_pulse) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_evt", int'(evt_count), e.evt);
                chk("pulse_alarm", int'(alarm), 1);
                chk("pulse_state", int'(state), 4);
`ifdef GLITCH_DIR_EN
                chk("pulse_dir", int'(glitch_dir), e.dir);
                chk("pulse_droop", int'(droop_count), e.droop);
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; alarm_clr = 1'b0;
        thresh = 7'd0; count_in = 7'd0; start2 = 1'b0; count2 = 7'd0;

        // Reset state.
        step(2);
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_baseline", int'(baseline), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_evt", int'(evt_count), 0);
        chk("rst_pulse", int'(glitch_pulse), 0);

        // Calibration: 1 + 8 + 16 edges from start to MONITOR.
        rst_n = 1'b1;
        thresh = 7'd4; count_in = 7'd45; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("settle_state", int'(state), 1);
        chk("settle_busy", int'(busy), 1);
        step(8);
        chk("cal_state", int'(state), 2);
        step(15);
        chk("cal_not_done", int'(state), 2);
        step(1);
        chk("mon_state", int'(state), 3);
        chk("mon_armed", int'(armed), 1);
        chk("cal_baseline", int'(baseline), 45);

        // Threshold edge: deviation 4 is not a detection, 5 is.
        count_in = 7'd49; step(1);
        count_in = 7'd41; step(1);
        chk("eq_thresh_state", int'(state), 3);
        count_in = 7'd50; expect_pulse(1, 0, 0); step(1);
        chk("det_state", int'(state), 4);
        chk("det_alarm", int'(alarm), 1);
        chk("det_armed", int'(armed), 0);
        count_in = 7'd45; step(16);
        chk("hold_done", int'(state), 3);

        // Droop detection.
        count_in = 7'd40; expect_pulse(2, 1, 1); step(1);
        count_in = 7'd45; step(16);
        chk("hold2_done", int'(state), 3);

        // Dead-time: constant offending count gives one pulse per 17 cycles.
        count_in = 7'd60;
        for (int i = 0; i < 51; i++) begin
            if ((i % 17) == 0) expect_pulse(3 + i / 17, 0, 1);
            step(1);
        end
        count_in = 7'd45;
        chk("deadtime_state", int'(state), 3);
        chk("deadtime_evt", int'(evt_count), 5);

        // Clear priority: set wins on the detection edge, clear wins afterwards.
        count_in = 7'd50; alarm_clr = 1'b1; expect_pulse(6, 0, 1); step(1);
        chk("clr_same_edge", int'(alarm), 1);
        count_in = 7'd45; step(1);
        chk("clr_next_edge", int'(alarm), 0);
        alarm_clr = 1'b0;
        step(15);
        chk("hold3_done", int'(state), 3);

        // start in MONITOR is ignored and thresh_r stays 4.
        thresh = 7'd0; start = 1'b1; step(1);
        start = 1'b0;
        chk("start_ignored", int'(state), 3);
        count_in = 7'd49; step(1);
        chk("thresh_kept", int'(state), 3);

        // stop beats a simultaneous detection.
        count_in = 7'd60; stop = 1'b1; step(1);
        stop = 1'b0;
        chk("stop_state", int'(state), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_evt", int'(evt_count), 6);
        chk("stop_baseline", int'(baseline), 45);

        // stop and start together in IDLE stay IDLE.
        thresh = 7'd2; stop = 1'b1; start = 1'b1; step(1);
        stop = 1'b0; start = 1'b0;
        chk("stop_start_idle", int'(state), 0);

        // Truncation: 8 x 40 + 8 x 41 = 648, >> 4 = 40.
        start = 1'b1; step(1);
        start = 1'b0;
        count_in = 7'd0; step(8);
        count_in = 7'd40; step(8);
        count_in = 7'd41; step(8);
        chk("trunc_state", int'(state), 3);
        chk("trunc_baseline", int'(baseline), 40);
        count_in = 7'd40; stop = 1'b1; step(1);
        stop = 1'b0;

        // stop during CAL leaves the baseline untouched.
        start = 1'b1; step(1);
        start = 1'b0;
        step(8);
        count_in = 7'd100; step(5);
        chk("abort_cal_state", int'(state), 2);
        stop = 1'b1; step(1);
        stop = 1'b0;
        chk("abort_cal_idle", int'(state), 0);
        chk("abort_cal_baseline", int'(baseline), 40);

        // Reset during HOLD clears everything.
        start = 1'b1; step(1);
        start = 1'b0;
        count_in = 7'd40; step(24);
        chk("run3_state", int'(state), 3);
        count_in = 7'd43; expect_pulse(7, 0, 1); step(1);
        chk("run3_hold", int'(state), 4);
        count_in = 7'd40; rst_n = 1'b0; step(1);
        chk("rst_hold_state", int'(state), 0);
        chk("rst_hold_baseline", int'(baseline), 0);
        chk("rst_hold_evt", int'(evt_count), 0);
        chk("rst_hold_alarm", int'(alarm), 0);
        chk("rst_hold_pulse", int'(glitch_pulse), 0);
        chk("rst_hold_busy", int'(busy), 0);
`ifdef GLITCH_DIR_EN
        chk("rst_hold_dir", int'(glitch_dir), 0);
        chk("rst_hold_droop", int'(droop_count), 0);
`endif
        rst_n = 1'b1;

        // Zero settle time and event counter saturation on the small instance.
        count2 = 7'd20; start2 = 1'b1; step(1);
        start2 = 1'b0;
        chk("z_settle", int'(state2), 1);
        step(1);
        chk("z_cal", int'(state2), 2);
        step(2);
        chk("z_mon", int'(state2), 3);
        chk("z_baseline", int'(baseline2), 20);
        count2 = 7'd30; step(20);
        chk("sat_full", int'(evt2), 7);
        step(7);
        chk("sat_hold", int'(evt2), 7);

        step(2);
        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
